// File: rtl/axi4_lite_rw_arbiter.sv
// Two-master / one-slave AXI4-Lite arbiter with independent read and write
// channel ownership, each round-robin and held from address to response.
module axi4_lite_rw_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    // master side, index 0 = IFU, index 1 = LSU
    input  logic [1:0][ADDR_WIDTH-1:0]        maraddr,
    input  logic [1:0]                        marvalid,
    output logic [1:0]                        marready,
    output logic [1:0][DATA_WIDTH-1:0]        mrdata,
    output logic [1:0][1:0]                   mrresp,
    output logic [1:0]                        mrvalid,
    input  logic [1:0]                        mrready,
    input  logic [1:0][ADDR_WIDTH-1:0]        mawaddr,
    input  logic [1:0]                        mawvalid,
    output logic [1:0]                        mawready,
    input  logic [1:0][DATA_WIDTH-1:0]        mwdata,
    input  logic [1:0][DATA_WIDTH/8-1:0]      mwstrb,
    input  logic [1:0]                        mwvalid,
    output logic [1:0]                        mwready,
    output logic [1:0][1:0]                   mbresp,
    output logic [1:0]                        mbvalid,
    input  logic [1:0]                        mbready,
    // slave side
    output logic [ADDR_WIDTH-1:0]             saraddr,
    output logic                              sarvalid,
    input  logic                              sarready,
    input  logic [DATA_WIDTH-1:0]             srdata,
    input  logic [1:0]                        srresp,
    input  logic                              srvalid,
    output logic                              srready,
    output logic [ADDR_WIDTH-1:0]             sawaddr,
    output logic                              sawvalid,
    input  logic                              sawready,
    output logic [DATA_WIDTH-1:0]             swdata,
    output logic [DATA_WIDTH/8-1:0]           swstrb,
    output logic                              swvalid,
    input  logic                              swready,
    input  logic [1:0]                        sbresp,
    input  logic                              sbvalid,
    output logic                              sbready,
    // channel ownership
    output logic [1:0]                        r_grant,
    output logic [1:0]                        w_grant
);

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} w_state_t;

    r_state_t r_state, r_state_nx;
    logic     r_owner, r_owner_nx;
    logic     r_last, r_last_nx;

    w_state_t w_state, w_state_nx;
    logic     w_owner, w_owner_nx;
    logic     w_last, w_last_nx;
    logic     aw_done, aw_done_nx;
    logic     w_done, w_done_nx;
    logic     aw_hs, w_hs;
    logic [1:0] w_req;

    // Single requester wins outright; on a tie the master not served last wins.
    function automatic logic pick(input logic [1:0] req, input logic last);
        if (req == 2'b11) begin
            return ~last;
        end
        return req[1];
    endfunction

    assign w_req = mawvalid | mwvalid;

    // ---------------- read channel ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            r_state <= r_state_nx;
            r_owner <= r_owner_nx;
            r_last  <= r_last_nx;
        end
    end

    always_comb begin
        r_state_nx = r_state;
        r_owner_nx = r_owner;
        r_last_nx  = r_last;
        marready   = '0;
        mrvalid    = '0;
        r_grant    = '0;
        sarvalid   = 1'b0;
        srready    = 1'b0;
        saraddr    = maraddr[r_owner];
        mrdata     = {2{srdata}};
        mrresp     = {2{srresp}};
        unique case (r_state)
            R_IDLE: begin
                if (|marvalid) begin
                    r_owner_nx = pick(marvalid, r_last);
                    r_state_nx = R_ADDR;
                end
            end
            R_ADDR: begin
                r_grant[r_owner]  = 1'b1;
                sarvalid          = marvalid[r_owner];
                marready[r_owner] = sarready;
                if (marvalid[r_owner] && sarready) begin
                    r_state_nx = R_DATA;
                end
            end
            R_DATA: begin
                r_grant[r_owner] = 1'b1;
                mrvalid[r_owner] = srvalid;
                srready          = mrready[r_owner];
                if (srvalid && mrready[r_owner]) begin
                    // re-arbitrate against the owner just served for zero idle cycles
                    r_last_nx = r_owner;
                    if (|marvalid) begin
                        r_owner_nx = pick(marvalid, r_owner);
                        r_state_nx = R_ADDR;
                    end else begin
                        r_state_nx = R_IDLE;
                    end
                end
            end
            default: r_state_nx = R_IDLE;
        endcase
    end

    // ---------------- write channel ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state <= W_IDLE;
            w_owner <= 1'b0;
            w_last  <= 1'b1;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            w_state <= w_state_nx;
            w_owner <= w_owner_nx;
            w_last  <= w_last_nx;
            aw_done <= aw_done_nx;
            w_done  <= w_done_nx;
        end
    end

    always_comb begin
        w_state_nx = w_state;
        w_owner_nx = w_owner;
        w_last_nx  = w_last;
        aw_done_nx = aw_done;
        w_done_nx  = w_done;
        aw_hs      = 1'b0;
        w_hs       = 1'b0;
        mawready   = '0;
        mwready    = '0;
        mbvalid    = '0;
        w_grant    = '0;
        sawvalid   = 1'b0;
        swvalid    = 1'b0;
        sbready    = 1'b0;
        sawaddr    = mawaddr[w_owner];
        swdata     = mwdata[w_owner];
        swstrb     = mwstrb[w_owner];
        mbresp     = {2{sbresp}};
        unique case (w_state)
            W_IDLE: begin
                if (|w_req) begin
                    w_owner_nx = pick(w_req, w_last);
                    w_state_nx = W_REQ;
                end
            end
            W_REQ: begin
                w_grant[w_owner]  = 1'b1;
                sawvalid          = mawvalid[w_owner] & ~aw_done;
                swvalid           = mwvalid[w_owner] & ~w_done;
                mawready[w_owner] = sawready & ~aw_done;
                mwready[w_owner]  = swready & ~w_done;
                aw_hs             = sawvalid & sawready;
                w_hs              = swvalid & swready;
                aw_done_nx        = aw_done | aw_hs;
                w_done_nx         = w_done | w_hs;
                if (aw_done_nx && w_done_nx) begin
                    w_state_nx = W_RESP;
                end
            end
            W_RESP: begin
                w_grant[w_owner] = 1'b1;
                mbvalid[w_owner] = sbvalid;
                sbready          = mbready[w_owner];
                if (sbvalid && mbready[w_owner]) begin
                    w_last_nx  = w_owner;
                    aw_done_nx = 1'b0;
                    w_done_nx  = 1'b0;
                    if (|w_req) begin
                        w_owner_nx = pick(w_req, w_owner);
                        w_state_nx = W_REQ;
                    end else begin
                        w_state_nx = W_IDLE;
                    end
                end
            end
            default: w_state_nx = W_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi4_lite_rw_arbiter.sv
// Scoreboarded bench: behavioural masters and slave drive the arbiter, expected
// read data / write payloads / responses are queued at issue and popped on delivery.
module tb_axi4_lite_rw_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam logic [31:0] RD_KEY = 32'h5EAD_BEEF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0][AW-1:0] maraddr  = '0;
    logic [1:0]         marvalid = '0;
    logic [1:0]         marready;
    logic [1:0][DW-1:0] mrdata;
    logic [1:0][1:0]    mrresp;
    logic [1:0]         mrvalid;
    logic [1:0]         mrready  = '1;
    logic [1:0][AW-1:0] mawaddr  = '0;
    logic [1:0]         mawvalid = '0;
    logic [1:0]         mawready;
    logic [1:0][DW-1:0] mwdata   = '0;
    logic [1:0][SW-1:0] mwstrb   = '0;
    logic [1:0]         mwvalid  = '0;
    logic [1:0]         mwready;
    logic [1:0][1:0]    mbresp;
    logic [1:0]         mbvalid;
    logic [1:0]         mbready  = '1;
    logic [AW-1:0]      saraddr;
    logic               sarvalid;
    logic               sarready = 1'b1;
    logic [DW-1:0]      srdata   = '0;
    logic [1:0]         srresp   = '0;
    logic               srvalid  = 1'b0;
    logic               srready;
    logic [AW-1:0]      sawaddr;
    logic               sawvalid;
    logic               sawready = 1'b1;
    logic [DW-1:0]      swdata;
    logic [SW-1:0]      swstrb;
    logic               swvalid;
    logic               swready  = 1'b1;
    logic [1:0]         sbresp   = '0;
    logic               sbvalid  = 1'b0;
    logic               sbready;
    logic [1:0]         r_grant;
    logic [1:0]         w_grant;

    axi4_lite_rw_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .maraddr(maraddr), .marvalid(marvalid), .marready(marready),
        .mrdata(mrdata), .mrresp(mrresp), .mrvalid(mrvalid), .mrready(mrready),
        .mawaddr(mawaddr), .mawvalid(mawvalid), .mawready(mawready),
        .mwdata(mwdata), .mwstrb(mwstrb), .mwvalid(mwvalid), .mwready(mwready),
        .mbresp(mbresp), .mbvalid(mbvalid), .mbready(mbready),
        .saraddr(saraddr), .sarvalid(sarvalid), .sarready(sarready),
        .srdata(srdata), .srresp(srresp), .srvalid(srvalid), .srready(srready),
        .sawaddr(sawaddr), .sawvalid(sawvalid), .sawready(sawready),
        .swdata(swdata), .swstrb(swstrb), .swvalid(swvalid), .swready(swready),
        .sbresp(sbresp), .sbvalid(sbvalid), .sbready(sbready),
        .r_grant(r_grant), .w_grant(w_grant)
    );

    logic [18:0] ctl;
    assign ctl = {r_grant, w_grant, sarvalid, srready, sawvalid, swvalid, sbready,
                  marready, mrvalid, mawready, mwready, mbvalid};

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int unsigned lead;
        bit          hold;
    } wcmd_t;

    logic [31:0] rd_cmd_q [2][$];
    wcmd_t       wr_cmd_q [2][$];
    logic [33:0] exp_rd_q [2][$];
    logic [67:0] exp_wr_q [2][$];
    logic [1:0]  exp_b_q  [2][$];
    logic [1:0]  ar_log[$];
    logic [1:0]  aw_log[$];
    int unsigned ar_cyc[$];
    int unsigned r_cyc[$];

    int unsigned rd_delay = 0;
    bit          aw_rdy   = 1'b1;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // master state
    bit          wr_busy [2];
    bit          aw_left [2];
    bit          w_left  [2];
    bit          hold    [2];
    int unsigned lead_cnt[2];
    // slave state
    bit          rd_pend, got_aw, got_w;
    int unsigned rd_cnt;
    logic [31:0] rd_addr, s_awaddr, s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wown;

    // Sample at negedge, drive 1 time unit after posedge.
    always begin : models
        bit          c_rst, c_ar, c_r, c_aw, c_w, c_b, c_wown;
        logic [31:0] c_araddr, c_awaddr, c_wdata, a;
        logic [3:0]  c_wstrb;
        logic [1:0]  c_marhs, c_mawhs, c_mwhs, c_mr, c_mb;
        wcmd_t       wc;
        @(negedge clk);
        c_rst    = rst;
        c_ar     = sarvalid & sarready;
        c_araddr = saraddr;
        c_r      = srvalid & srready;
        c_aw     = sawvalid & sawready;
        c_awaddr = sawaddr;
        c_w      = swvalid & swready;
        c_wdata  = swdata;
        c_wstrb  = swstrb;
        c_wown   = w_grant[1];
        c_b      = sbvalid & sbready;
        c_marhs  = marvalid & marready;
        c_mawhs  = mawvalid & mawready;
        c_mwhs   = mwvalid & mwready;
        c_mr     = mrvalid & mrready;
        c_mb     = mbvalid & mbready;
        if (c_ar) begin ar_log.push_back(r_grant); ar_cyc.push_back(cyc); end
        if (c_r)  r_cyc.push_back(cyc);
        if (c_aw) aw_log.push_back(w_grant);
        for (int m = 0; m < 2; m++) begin
            if (c_mr[m]) begin
                if (exp_rd_q[m].size() == 0) check("rd_unexpected", c_mr[m], 1'b0);
                else check("rd_data", {mrresp[m], mrdata[m]}, exp_rd_q[m].pop_front());
                check("rd_other_valid", mrvalid[1-m], 1'b0);
            end
            if (c_mb[m]) begin
                if (exp_b_q[m].size() == 0) check("b_unexpected", c_mb[m], 1'b0);
                else check("bresp", mbresp[m], exp_b_q[m].pop_front());
                check("b_other_valid", mbvalid[1-m], 1'b0);
            end
            if (wr_busy[m] && hold[m] && !w_left[m] && aw_left[m])
                check("w_masked", {swvalid, mwready[m], mbvalid[m]}, 3'b000);
        end

        @(posedge clk);
        #1;
        if (c_rst) begin
            marvalid = '0; mawvalid = '0; mwvalid = '0;
            srvalid = 1'b0; sbvalid = 1'b0;
            rd_pend = 1'b0; got_aw = 1'b0; got_w = 1'b0;
            for (int m = 0; m < 2; m++) begin
                wr_busy[m] = 1'b0; aw_left[m] = 1'b0; w_left[m] = 1'b0; hold[m] = 1'b0;
                rd_cmd_q[m].delete(); wr_cmd_q[m].delete();
                exp_rd_q[m].delete(); exp_wr_q[m].delete(); exp_b_q[m].delete();
            end
        end else begin
            // slave read side
            if (c_r) srvalid = 1'b0;
            if (c_ar) begin rd_pend = 1'b1; rd_cnt = rd_delay; rd_addr = c_araddr; end
            if (rd_pend && !srvalid) begin
                if (rd_cnt == 0) begin
                    srvalid = 1'b1; srdata = rd_addr ^ RD_KEY; srresp = rd_addr[3:2]; rd_pend = 1'b0;
                end else begin
                    rd_cnt--;
                end
            end
            // slave write side
            if (c_b) sbvalid = 1'b0;
            if (c_aw) begin got_aw = 1'b1; s_awaddr = c_awaddr; end
            if (c_w) begin got_w = 1'b1; s_wdata = c_wdata; s_wstrb = c_wstrb; s_wown = c_wown; end
            if (got_aw && got_w) begin
                if (exp_wr_q[s_wown].size() == 0) check("wr_unexpected", got_w, 1'b0);
                else check("wr_payload", {s_awaddr, s_wdata, s_wstrb}, exp_wr_q[s_wown].pop_front());
                sbvalid = 1'b1; sbresp = s_awaddr[5:4];
                got_aw = 1'b0; got_w = 1'b0;
            end
            // masters
            for (int m = 0; m < 2; m++) begin
                if (c_marhs[m]) marvalid[m] = 1'b0;
                if (!marvalid[m] && rd_cmd_q[m].size() != 0) begin
                    a = rd_cmd_q[m].pop_front();
                    maraddr[m] = a; marvalid[m] = 1'b1;
                    exp_rd_q[m].push_back({a[3:2], a ^ RD_KEY});
                end
                if (c_mawhs[m]) begin
                    mawvalid[m] = 1'b0; aw_left[m] = 1'b0;
                    if (hold[m]) mwvalid[m] = 1'b0;
                end
                if (c_mwhs[m]) begin
                    w_left[m] = 1'b0;
                    if (!hold[m]) mwvalid[m] = 1'b0;
                end
                if (wr_busy[m] && aw_left[m] && !mawvalid[m]) begin
                    if (lead_cnt[m] == 0) mawvalid[m] = 1'b1;
                    else lead_cnt[m]--;
                end
                if (c_mb[m]) wr_busy[m] = 1'b0;
                if (!wr_busy[m] && wr_cmd_q[m].size() != 0) begin
                    wc = wr_cmd_q[m].pop_front();
                    mawaddr[m] = wc.addr; mwdata[m] = wc.data; mwstrb[m] = wc.strb;
                    mwvalid[m] = 1'b1; mawvalid[m] = (wc.lead == 0);
                    lead_cnt[m] = (wc.lead == 0) ? 0 : wc.lead - 1;
                    hold[m] = wc.hold; aw_left[m] = 1'b1; w_left[m] = 1'b1; wr_busy[m] = 1'b1;
                    exp_wr_q[m].push_back({wc.addr, wc.data, wc.strb});
                    exp_b_q[m].push_back(wc.addr[5:4]);
                end
            end
        end
        sawready = aw_rdy;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_read(input int m, input logic [31:0] addr);
        rd_cmd_q[m].push_back(addr);
    endtask

    task automatic push_write(input int m, input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input int unsigned lead, input bit hd);
        wcmd_t wc;
        wc.addr = addr; wc.data = data; wc.strb = strb; wc.lead = lead; wc.hold = hd;
        wr_cmd_q[m].push_back(wc);
    endtask

    task automatic clear_logs();
        ar_log.delete(); aw_log.delete(); ar_cyc.delete(); r_cyc.delete();
    endtask

    task automatic wait_idle(input string tag, input int unsigned maxc);
        bit done = 1'b0;
        for (int unsigned i = 0; i < maxc && !done; i++) begin
            step();
            done = 1'b1;
            for (int m = 0; m < 2; m++) begin
                if (rd_cmd_q[m].size() != 0 || wr_cmd_q[m].size() != 0 || exp_rd_q[m].size() != 0 ||
                    exp_wr_q[m].size() != 0 || exp_b_q[m].size() != 0 || wr_busy[m] || marvalid[m])
                    done = 1'b0;
            end
            if (r_grant != 2'b00 || w_grant != 2'b00 || srvalid || sbvalid) done = 1'b0;
        end
        check(tag, done, 1'b1);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        bit seen;

        // reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        step();
        check("reset_outputs", ctl, 19'd0);

        // read tie fairness
        clear_logs();
        push_read(0, 32'h0000_1000); push_read(0, 32'h0000_1004);
        push_read(1, 32'h0000_2000); push_read(1, 32'h0000_2008);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            step();
            if (r_cyc.size() >= 4) seen = 1'b1;
        end
        check("tie_done", seen, 1'b1);
        if (seen) begin
            for (int i = 0; i < 4; i++) check("tie_grant", ar_log[i], (i % 2 == 0) ? 2'b01 : 2'b10);
            for (int i = 0; i < 3; i++) check("tie_gap", ar_cyc[i+1], r_cyc[i] + 1);
        end
        wait_idle("tie_idle", 20);

        // solo read
        push_read(0, 32'h8000_0000);
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin step(); seen = marvalid[0]; end
        check("solo_req", seen, 1'b1);
        step();
        check("solo_grant", {r_grant, sarvalid}, 3'b011);
        check("solo_araddr", saraddr, 32'h8000_0000);
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin step(); seen = mrvalid[0]; end
        check("solo_rvalid", seen, 1'b1);
        check("solo_rdata", {mrvalid[1], mrdata[0]}, {1'b0, 32'hDEAD_BEEF});
        wait_idle("solo_idle", 10);

        // concurrent read (m0) and write (m1)
        push_read(0, 32'h0000_0040);
        push_write(1, 32'hA000_0000, 32'h1234_5678, 4'hF, 0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin step(); seen = marvalid[0] & mwvalid[1]; end
        check("conc_req", seen, 1'b1);
        step();
        check("conc_grants", {r_grant, w_grant}, 4'b0110);
        wait_idle("conc_idle", 20);

        // W leads AW by two cycles, W kept asserted after its handshake
        clear_logs();
        push_write(1, 32'hA000_0000, 32'hCAFE_F00D, 4'h3, 2, 1'b1);
        wait_idle("order_idle", 20);
        check("order_aw_grant", aw_log.size() > 0 ? aw_log[0] : 2'b00, 2'b10);

        // hold under contention
        rd_delay = 5;
        push_read(0, 32'h0000_0100);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            seen = sarvalid & sarready & (r_grant == 2'b01);
        end
        check("hold_ar", seen, 1'b1);
        push_read(1, 32'h0000_0200);
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            step();
            if (srvalid && srready) seen = 1'b1;
            else check("hold_wait", {marready[1], r_grant}, 3'b001);
        end
        check("hold_rhs", {seen, r_grant}, 3'b101);
        step();
        check("hold_next", {r_grant, sarvalid, marready[1]}, 4'b1011);
        rd_delay = 0;
        wait_idle("hold_idle", 20);

        // reset in R_DATA and W_REQ
        rd_delay = 30;
        aw_rdy = 1'b0;
        push_read(0, 32'h0000_0300);
        push_write(1, 32'hA000_0010, 32'h0BAD_F00D, 4'hC, 0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            seen = (r_grant == 2'b01) & ~sarvalid & (w_grant == 2'b10) & ~swvalid;
        end
        check("mrst_reach", seen, 1'b1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        step();
        check("mrst_outputs", ctl, 19'd0);
        rd_delay = 0;
        aw_rdy = 1'b1;
        clear_logs();
        push_read(1, 32'h0000_0400);
        push_read(0, 32'h0000_0504);
        push_write(1, 32'hA000_0030, 32'h5555_AAAA, 4'h1, 0, 1'b0);
        push_write(0, 32'hA000_0010, 32'h7777_8888, 4'hF, 0, 1'b0);
        wait_idle("mrst_idle", 60);
        check("mrst_first_rd", ar_log.size() > 0 ? ar_log[0] : 2'b00, 2'b01);
        check("mrst_first_wr", aw_log.size() > 0 ? aw_log[0] : 2'b00, 2'b01);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axi4_lite_rw_arbiter.md
# axi4_lite_rw_arbiter

Two-master, one-slave AXI4-Lite arbiter with independent read-channel and write-channel arbitration, so one master's read and the other master's write can be in flight together. It sits between the IFU/LSU master ports and the shared memory/peripheral slave port of the pipelined core. Each channel uses its own round-robin grant and holds that grant from address handshake through response handshake.

## Interface
- ADDR_WIDTH, 32, address width of all AR/AW buses
- DATA_WIDTH, 32, data width of R/W buses; strobe width is DATA_WIDTH/8
- clk  in  1  clock; all logic is rising-edge
- rst  in  1  reset; synchronous, active-high
- Master side, packed [1:0] per signal, index 0 = IFU, index 1 = LSU:
  - maraddr/marvalid/marready; mrdata/mrresp/mrvalid/mrready
  - mawaddr/mawvalid/mawready; mwdata/mwstrb/mwvalid/mwready; mbresp/mbvalid/mbready
- Slave side, single channel:
  - saraddr/sarvalid/sarready; srdata/srresp/srvalid/srready
  - sawaddr/sawvalid/sawready; swdata/swstrb/swvalid/swready; sbresp/sbvalid/sbready
- r_grant  out  2  one-hot owner of the read channel; 0 when idle
- w_grant  out  2  one-hot owner of the write channel; 0 when idle

## Operation
- **Read FSM states:** R_IDLE, R_ADDR, R_DATA. Registers: r_owner (1 bit), r_last (last master served).
  - R_IDLE → R_ADDR when any marvalid is set. Owner = the single requester. If both request, owner = ~r_last.
  - R_ADDR: sarvalid = marvalid[owner]; saraddr = maraddr[owner]; marready[owner] = sarready. On the AR handshake → R_DATA.
  - R_DATA: mrvalid[owner] = srvalid; srready = mrready[owner]. On the R handshake, r_last ← owner. Then:
    - If any marvalid is set in that cycle, re-arbitrate with the updated r_last and go directly to R_ADDR.
    - Otherwise go to R_IDLE.
- **Write FSM states:** W_IDLE, W_REQ, W_RESP. Registers: w_owner, w_last, aw_done, w_done.
  - W_IDLE → W_REQ when any (mawvalid | mwvalid) is set. Arbitration is the same as the read side, using w_last.
  - W_REQ:
    - sawvalid = mawvalid[owner] & ~aw_done; swvalid = mwvalid[owner] & ~w_done.
    - mawready[owner] = sawready & ~aw_done; mwready[owner] = swready & ~w_done.
    - Each handshake sets its done flag. AW and W may complete in either order or in the same cycle.
    - → W_RESP in the cycle where both are complete (registered flag or current handshake).
  - W_RESP: mbvalid[owner] = sbvalid; sbready = mbready[owner]. On the B handshake: w_last ← owner, both done flags clear, then re-arbitrate or go to W_IDLE, the same way as the read side.
- **Non-owners:**
  - Every ready and valid output toward a non-owner master is 0.
  - mrdata, mrresp and mbresp are broadcast to both masters.
  - Slave-side payload muxes select by owner; the selected value while idle is don't-care.
- **Concurrency:** the read and write FSMs are fully independent. Both may grant the same master, or different masters, in the same cycle.
- **Protocol assumptions:**
  - Masters hold valid and payload stable until handshake; dropping valid early is unsupported.
  - The slave never asserts srvalid or sbvalid outside the matching response state. If it does, that response is forwarded to no one.

## Timing
- **Reset:**
  - Both FSMs go to IDLE; r_last = w_last = 1, so master 0 wins the first tie; done flags = 0.
  - All valid/ready outputs are 0; r_grant = w_grant = 0.
- **Latency:**
  - First grant: one registered cycle from the request (valid seen in IDLE) to sarvalid/sawvalid.
  - Back-to-back: zero idle cycles between the response handshake and the next AR/AW.
- **Grant hold:** the grant never changes between the address handshake and the response handshake.
- **Simultaneous events:**
  - A new request arriving in the same cycle as a response handshake is considered in that cycle's re-arbitration.
  - AW and W completing in the same cycle → W_RESP next cycle.
- **Reset mid-transaction:** the transaction is abandoned and the FSM returns to IDLE on the next edge. The slave is reset by the same rst.
- Combinational paths: slave ready → master ready, and slave valid → master valid. No registered stage is added on data.

## Test plan
- **Solo read:**
  - Stimulus: m0 reads 0x8000_0000; slave sarready=1, returns srdata=0xDEADBEEF one cycle later.
  - Required: r_grant=01 one cycle after marvalid; mrvalid[0]=1 with data 0xDEADBEEF; mrvalid[1]=0; back to R_IDLE.
- **Read tie fairness:**
  - Stimulus: m0 and m1 both assert marvalid continuously for 4 reads.
  - Required: grant order is m0, m1, m0, m1, with zero idle cycles between transactions.
- **Concurrent read/write:**
  - Stimulus: m0 reads while m1 writes 0x1234_5678 with wstrb=0xF to 0xA000_0000.
  - Required: r_grant=01 and w_grant=10 in the same cycle; both complete independently.
- **Write ordering:**
  - Stimulus: m1 presents W two cycles before AW.
  - Required: swvalid is dropped after the W handshake; W_RESP is entered only after the AW handshake; mbvalid[1] is forwarded with bresp=00.
- **Hold under contention:**
  - Stimulus: m1 raises marvalid while m0 waits 5 cycles for srvalid.
  - Required: marready[1] stays 0 and r_grant stays 01 until m0's R handshake; m1 is granted in the next cycle.
- **Mid-transaction reset:**
  - Stimulus: rst is asserted in R_DATA and W_REQ.
  - Required: next cycle all valid/ready outputs are 0, grants are 0; a following m0 request is granted first.
